// File: rtl/sign_extend.sv
// Registered sign/zero extension of an immediate field of selectable width.
// Optional zero-extend select is built in when SIGN_EXTEND_ZEXT_EN is defined.
module sign_extend #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  A,
    input  logic [1:0]       width_sel,
`ifdef SIGN_EXTEND_ZEXT_EN
    input  logic             zext,
`endif
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    // Field width selected by each width_sel code.
    function automatic int field_w(input int sel);
        case (sel)
            0:       return IN_W;
            1:       return 16;
            2:       return 12;
            default: return 8;
        endcase
    endfunction

    logic             zero_fill;
    logic [OUT_W-1:0] ext [4];
    logic [OUT_W-1:0] ext_sel;

`ifdef SIGN_EXTEND_ZEXT_EN
    assign zero_fill = zext;
`else
    assign zero_fill = 1'b0;
`endif

    // One extender per width code; a field wider than A is clamped to IN_W.
    for (genvar k = 0; k < 4; k++) begin : g_width
        localparam int W   = field_w(k);
        localparam int EFF = (W < IN_W) ? W : IN_W;

        if (EFF >= OUT_W) begin : g_trunc
            assign ext[k] = A[OUT_W-1:0];
        end else begin : g_ext
            logic fill;
            assign fill   = A[EFF-1] & ~zero_fill;
            assign ext[k] = {{(OUT_W-EFF){fill}}, A[EFF-1:0]};
        end
    end

    always_comb begin
        ext_sel = ext[width_sel];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the data register is reset too, so no stale
    // result can ever be observed after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= ext_sel;
            end
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: directed vectors plus randomized
// traffic against a value-level arithmetic model.
module tb_sign_extend;

    localparam int IN_W  = 21;
    localparam int OUT_W = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [IN_W-1:0]  A;
    logic [1:0]       width_sel;
    logic             zext;
    logic [OUT_W-1:0] out;
    logic             out_valid;

    int checks;
    int errors;

    sign_extend #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .width_sel (width_sel),
`ifdef SIGN_EXTEND_ZEXT_EN
        .zext      (zext),
`endif
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value-level model: take the low W bits as a number, and if treated as
    // signed and the top bit is set, subtract 2**W, then keep OUT_W bits.
    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] a,
                                               input logic [1:0] sel,
                                               input logic z);
        int     w;
        longint field;
        longint v;
        logic   use_zero;
        case (sel)
            2'd0:    w = IN_W;
            2'd1:    w = 16;
            2'd2:    w = 12;
            default: w = 8;
        endcase
        if (w > IN_W) w = IN_W;
`ifdef SIGN_EXTEND_ZEXT_EN
        use_zero = z;
`else
        use_zero = 1'b0;
        if (z) use_zero = 1'b0;
`endif
        field = longint'(a) % (64'sd1 <<< w);
        if (!use_zero && field >= (64'sd1 <<< (w - 1)))
            v = field - (64'sd1 <<< w);
        else
            v = field;
        return v[OUT_W-1:0];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; A = '0; width_sel = 2'd0; zext = 1'b0;
        #3;
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h out_valid=%b, expected 0/0", out, out_valid);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: out=%h out_valid=%b, expected 0/0", out, out_valid);
        end
    endtask

    task automatic test_widths();
        logic [IN_W-1:0]  av [5] = '{21'h06A300, 21'h1EA300, 21'h1EA300, 21'h1EA300, 21'h1EA300};
        logic [1:0]       sv [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [OUT_W-1:0] ev [5] = '{32'h0006A300, 32'hFFFEA300, 32'hFFFFA300,
                                     32'h00000300, 32'h00000000};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; A = av[i]; width_sel = sv[i]; zext = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (out !== ev[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL width_vec%0d: out=%h valid=%b, expected %h valid=1",
                         i, out, out_valid, ev[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        in_valid = 1'b1; A = 21'h1EA300; width_sel = 2'd0; zext = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out !== 32'hFFFEA300 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_capture: out=%h valid=%b, expected fffea300 valid=1", out, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; A = IN_W'($urandom); width_sel = 2'($urandom); zext = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out !== 32'hFFFEA300 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: out=%h valid=%b, expected fffea300 valid=0",
                         i, out, out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0; in_valid = 1'b1; A = 21'h06A300; width_sel = 2'd0;
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: out=%h valid=%b, expected 0/0", out, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_held: out=%h valid=%b, expected 0/0", out, out_valid);
        end
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_stale: out=%h valid=%b, expected 0/0", out, out_valid);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h0006A300 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_recapture: out=%h valid=%b, expected 0006a300 valid=1",
                     out, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0]  av [3] = '{21'h100000, 21'h0FFFFF, 21'h1FFFFF};
        logic [OUT_W-1:0] ev [3] = '{32'hFFF00000, 32'h000FFFFF, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; A = av[i]; width_sel = 2'd0; zext = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (out !== ev[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream%0d: out=%h valid=%b, expected %h valid=1",
                         i, out, out_valid, ev[i]);
            end
        end
        in_valid = 1'b0;
    endtask

`ifdef SIGN_EXTEND_ZEXT_EN
    task automatic test_zext();
        logic             zv [2] = '{1'b1, 1'b0};
        logic [OUT_W-1:0] ev [2] = '{32'h001EA300, 32'hFFFEA300};
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; A = 21'h1EA300; width_sel = 2'd0; zext = zv[i];
            @(posedge clk); #1;
            checks++;
            if (out !== ev[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL zext%0d: out=%h valid=%b, expected %h valid=1",
                         i, out, out_valid, ev[i]);
            end
        end
        in_valid = 1'b0; zext = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [OUT_W-1:0] exp_out;
        logic             exp_valid;
        exp_out = out;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = IN_W'($urandom);
            width_sel = 2'($urandom);
            zext      = 1'($urandom);
            if (in_valid) exp_out = model(A, width_sel, zext);
            exp_valid = in_valid;
            @(posedge clk); #1;
            checks++;
            if (out !== exp_out || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL random%0d: out=%h valid=%b, expected %h valid=%b",
                         i, out, out_valid, exp_out, exp_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_widths();
        test_hold();
        test_async_reset();
        test_back_to_back();
`ifdef SIGN_EXTEND_ZEXT_EN
        test_zext();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_extend.md
SIGN_EXTEND -- requirements
Module: sign_extend

Interface
REQ-001 Parameter IN_W, default 21, width of source field A; legal range 8..OUT_W.
REQ-002 Parameter OUT_W, default 32, width of extended result.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  A/width_sel/zext sampled when high.
REQ-006 A  input  IN_W  source immediate; bit IN_W-1 is the full-width sign bit.
REQ-007 width_sel  input  2  effective field width: 00 = IN_W bits, 01 = 16 bits, 10 = 12 bits, 11 = 8 bits.
REQ-008 zext  input  1  zero-extend select; present only when SIGN_EXTEND_ZEXT_EN is defined.
REQ-009 out  output  OUT_W  registered extended result.
REQ-010 out_valid  output  1  high for the cycle in which out carries a newly captured result.

Function
REQ-011 Effective width W: IN_W, 16, 12 or 8 per width_sel; the field is A[W-1:0]; bits of A at or above W are ignored.
REQ-012 Sign extension: out[W-1:0] = A[W-1:0]; out[OUT_W-1:W] = copies of A[W-1].
REQ-013 Zero extension (zext=1, macro defined only): out[W-1:0] = A[W-1:0]; out[OUT_W-1:W] = 0.
REQ-014 If W >= OUT_W, out = A[OUT_W-1:0] with no extension bits.
REQ-015 Latency: exactly 1 cycle; inputs sampled on edge N with in_valid=1 appear on out, with out_valid=1, after edge N.
REQ-016 in_valid=0 at an edge: out holds its previous value; out_valid=0.
REQ-017 Back-to-back in_valid: one result per cycle, no bubbles, no stall or back-pressure input.
REQ-018 out depends only on registered state; no combinational path from any input to out or out_valid.
REQ-019 width_sel and zext are sampled together with A; a change while in_valid=0 has no effect on out.

Reset
REQ-020 rst_n low: out = 0 and out_valid = 0 immediately, with no dependence on clk.
REQ-021 Release of rst_n takes effect at the next rising clk; first capture is on the first edge with rst_n high and in_valid=1.
REQ-022 Assertion of rst_n mid-stream discards the pending capture; no stale result appears after release.

Configuration
REQ-023 Macro SIGN_EXTEND_ZEXT_EN defined: zext port exists and REQ-013 applies when zext=1.
REQ-024 Macro SIGN_EXTEND_ZEXT_EN undefined: zext port is absent and every capture uses sign extension (REQ-012).

Verification
REQ-025 width_sel=00, A=21'h06A300, in_valid=1 -> after one edge out=32'h0006A300, out_valid=1.
REQ-026 width_sel=00, A=21'h1EA300 -> out=32'hFFFEA300; with width_sel=01 -> 32'hFFFFA300; 10 -> 32'h00000300; 11 -> 32'h00000000.
REQ-027 A=21'h1EA300 captured, then in_valid=0 for 3 cycles with A changed -> out stays 32'hFFFEA300, out_valid=0.
REQ-028 Drive rst_n low mid-cycle while out=32'hFFFEA300 -> out=0 and out_valid=0 before the next clk edge; both stay 0 until a new valid capture.
REQ-029 SIGN_EXTEND_ZEXT_EN defined, zext=1, width_sel=00, A=21'h1EA300 -> out=32'h001EA300; zext=0 -> 32'hFFFEA300.
REQ-030 Stream A = 21'h100000, 21'h0FFFFF, 21'h1FFFFF on consecutive cycles (width_sel=00) -> out = 32'hFFF00000, 32'h000FFFFF, 32'hFFFFFFFF on consecutive cycles.
